// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: synchronised and filtered clock, framed receive FSM with
// timeout, scan-code FIFO and CPU data/status registers with IRQ and BUSY outputs.
`timescale 1ns/1ps
module ps2_kbd_ctrl #(
  parameter int FILT    = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 32768
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KB_CLK,
  input  logic       KB_DATA,
  input  logic       CS,
  input  logic       RD,
  input  logic       A0,
  output logic [7:0] DOUT,
  output logic       DOUT_OE,
  output logic       IRQ,
  output logic       BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;
  localparam logic [3:0]  FILT_LAST = 4'(FILT - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [AW:0] DEPTH_C   = (AW + 1)'(DEPTH);

  function automatic logic odd_ones(input logic [7:0] data, input logic par);
    odd_ones = ^{data, par};
  endfunction

  logic kbc_m_q, kbc_s_q, kbd_m_q, kbd_s_q;
  logic filt_q, filt_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic ev_s;
  logic [1:0] state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic par_q, par_d;
  logic [15:0] tmo_q, tmo_d;
  logic push_s, perr_set_s, ferr_set_s;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q, cnt_d;
  logic empty_s, full_s, do_push_s, do_pop_s, ovr_set_s;
  logic ovr_q, perr_q, ferr_q, irq_q;
  logic rd_act_s, rd_q, a0_q, rd_fall_s, pop_req_s, clr_s;
  logic [7:0] status_s;

  // Two-flop synchronisers; idle line level is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      kbc_m_q <= 1'b1;
      kbc_s_q <= 1'b1;
      kbd_m_q <= 1'b1;
      kbd_s_q <= 1'b1;
    end else begin
      kbc_m_q <= KB_CLK;
      kbc_s_q <= kbc_m_q;
      kbd_m_q <= KB_DATA;
      kbd_s_q <= kbd_m_q;
    end
  end

  always_comb begin
    filt_d = filt_q;
    fcnt_d = 4'd0;
    if (kbc_s_q != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = ~filt_q;
        fcnt_d = 4'd0;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end else begin
      fcnt_d = 4'd0;
    end
  end

  assign ev_s = filt_q & ~filt_d;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    push_s     = 1'b0;
    perr_set_s = 1'b0;
    ferr_set_s = 1'b0;
    tmo_d      = 16'd0;
    case (state_q)
      ST_IDLE: begin
        if (ev_s && !kbd_s_q) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (ev_s) begin
          shift_d = {kbd_s_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (ev_s) begin
          par_d   = kbd_s_q;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (ev_s) begin
          state_d = ST_IDLE;
          if (!kbd_s_q) begin
            ferr_set_s = 1'b1;
          end else if (!odd_ones(shift_q, par_q)) begin
            perr_set_s = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A stalled frame is aborted TIMEOUT cycles after its last bit event.
    if (state_q != ST_IDLE && !ev_s && tmo_q == TMO_LAST) begin
      state_d    = ST_IDLE;
      ferr_set_s = 1'b1;
    end else begin
      ferr_set_s = ferr_set_s;
    end
    if (ev_s || state_q == ST_IDLE) begin
      tmo_d = 16'd0;
    end else begin
      tmo_d = tmo_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_q  <= 1'b1;
      fcnt_q  <= 4'd0;
      state_q <= ST_IDLE;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      tmo_q   <= 16'd0;
    end else begin
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
    end
  end

  assign rd_act_s  = CS & RD;
  assign rd_fall_s = rd_q & ~rd_act_s;
  assign pop_req_s = rd_fall_s & ~a0_q;
  assign clr_s     = rd_fall_s & a0_q;
  assign empty_s   = (cnt_q == '0);
  assign full_s    = (cnt_q == DEPTH_C);
  assign do_pop_s  = pop_req_s & ~empty_s;
  assign do_push_s = push_s & (~full_s | do_pop_s);
  assign ovr_set_s = push_s & full_s & ~do_pop_s;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push_s && !do_pop_s) begin
      cnt_d = cnt_q + (AW + 1)'(1);
    end else if (do_pop_s && !do_push_s) begin
      cnt_d = cnt_q - (AW + 1)'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Side effects fire when the CPU read strobe ends, so DOUT is stable during the access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q   <= 1'b0;
      a0_q   <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      rd_q   <= rd_act_s;
      a0_q   <= rd_act_s ? A0 : a0_q;
      wp_q   <= do_push_s ? wp_q + AW'(1) : wp_q;
      rp_q   <= do_pop_s ? rp_q + AW'(1) : rp_q;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_set_s | (ovr_q & ~clr_s);
      perr_q <= perr_set_s | (perr_q & ~clr_s);
      ferr_q <= ferr_set_s | (ferr_q & ~clr_s);
      irq_q  <= ~empty_s | ovr_q | perr_q | ferr_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push_s) begin
      mem_q[wp_q] <= shift_q;
    end
  end

  assign BUSY     = (state_q != ST_IDLE);
  assign status_s = {2'b00, BUSY, ferr_q, perr_q, ovr_q, full_s, ~empty_s};

  always_comb begin
    DOUT = 8'h00;
    if (!rd_act_s) begin
      DOUT = 8'h00;
    end else if (A0) begin
      DOUT = status_s;
    end else if (empty_s) begin
      DOUT = 8'h00;
    end else begin
      DOUT = mem_q[rp_q];
    end
  end

  assign DOUT_OE = rd_act_s;
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed and randomized PS/2 frames against
// a queue-based model of the FIFO and status flags.
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;
  localparam int FILT  = 4;
  localparam int DEPTH = 8;
  localparam int TMO   = 1000;
  localparam int HALF  = 40;

  logic CLK = 1'b0, RST = 1'b1, KB_CLK = 1'b1, KB_DATA = 1'b1;
  logic CS = 1'b0, RD = 1'b0, A0 = 1'b0;
  logic [7:0] DOUT;
  logic DOUT_OE, IRQ, BUSY;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  bit m_ovr, m_perr, m_ferr;

  ps2_kbd_ctrl #(.FILT(FILT), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .KB_CLK(KB_CLK), .KB_DATA(KB_DATA),
    .CS(CS), .RD(RD), .A0(A0), .DOUT(DOUT), .DOUT_OE(DOUT_OE), .IRQ(IRQ), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic m_irq();
    return (mq.size() != 0) || m_ovr || m_perr || m_ferr;
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    if (stop_bad) m_ferr = 1'b1;
    else if (par_bad) m_perr = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic model_data(output logic [7:0] e);
    if (mq.size() == 0) e = 8'h00;
    else e = mq.pop_front();
  endtask

  task automatic model_status(output logic [7:0] e);
    e = {2'b00, 1'b0, m_ferr, m_perr, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
    m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic ps2_bit(input logic b);
    KB_DATA = b;
    repeat (HALF) @(negedge CLK);
    KB_CLK = 1'b0;
    repeat (HALF) @(negedge CLK);
    KB_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad, input bit chk_busy);
    logic [10:0] bits;
    bits = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_bit(bits[i]);
      if (chk_busy && i == 4) begin
        checks++;
        if (BUSY !== 1'b1) begin
          errors++; $display("FAIL busy_in_frame got %b want 1", BUSY);
        end
      end
    end
    KB_DATA = 1'b1;
    repeat (30) @(negedge CLK);
    if (chk_busy) begin
      checks++;
      if (BUSY !== 1'b0) begin
        errors++; $display("FAIL busy_after_frame got %b want 0", BUSY);
      end
    end
    model_frame(b, par_bad, stop_bad);
  endtask

  task automatic cpu_read(input logic a, output logic [7:0] d);
    @(negedge CLK);
    CS = 1'b1; RD = 1'b1; A0 = a;
    repeat (2) @(negedge CLK);
    d = DOUT;
    checks++;
    if (DOUT_OE !== 1'b1) begin
      errors++; $display("FAIL dout_oe got %b want 1", DOUT_OE);
    end
    CS = 1'b0; RD = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic read_status(input string name);
    logic [7:0] got, exp;
    cpu_read(1'b1, got);
    model_status(exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s status got %h want %h", name, got, exp);
    end
  endtask

  task automatic read_data(input string name);
    logic [7:0] got, exp;
    cpu_read(1'b0, got);
    model_data(exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s data got %h want %h", name, got, exp);
    end
  endtask

  task automatic check_irq(input string name);
    checks++;
    if (IRQ !== m_irq()) begin
      errors++; $display("FAIL %s irq got %b want %b", name, IRQ, m_irq());
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({DOUT, DOUT_OE, IRQ, BUSY} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs got %h/%b/%b/%b want 0", DOUT, DOUT_OE, IRQ, BUSY);
    end
    read_status("reset");
  endtask

  task automatic test_valid();
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    check_irq("valid_pre");
    // status read clears nothing here but must show AVAIL only
    begin
      logic [7:0] got;
      cpu_read(1'b1, got);
      checks++;
      if (got !== 8'h01) begin
        errors++; $display("FAIL valid_status got %h want 01", got);
      end
    end
    read_data("valid");
    read_status("valid_after");
    check_irq("valid_after");
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b1, 1'b0, 1'b1);
    check_irq("parity");
    read_status("parity_first");
    read_status("parity_second");
    check_irq("parity_cleared");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    check_irq("ovr");
    read_status("ovr_full");
    for (int i = 0; i < 8; i++) read_data("ovr_drain");
    read_status("ovr_empty");
  endtask

  task automatic test_timeout();
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'($urandom_range(0, 1)));
    repeat (TMO - 100) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL timeout_before got %b want 1", BUSY);
    end
    repeat (150) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL timeout_after got %b want 0", BUSY);
    end
    m_ferr = 1'b1;
    check_irq("timeout");
    read_status("timeout");
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    read_data("timeout_5a");
  endtask

  task automatic test_glitch();
    KB_DATA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      KB_CLK = 1'b0;
      repeat (2) @(negedge CLK);
      KB_CLK = 1'b1;
      repeat (10) @(negedge CLK);
    end
    repeat (10) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL glitch_busy got %b want 0", BUSY);
    end
    read_status("glitch");
    KB_CLK = 1'b0;
    repeat (FILT + 1) @(negedge CLK);
    KB_CLK = 1'b1;
    repeat (10) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL pulse_busy got %b want 1", BUSY);
    end
    KB_DATA = 1'b1;
    repeat (TMO + 20) @(negedge CLK);
    m_ferr = 1'b1;
    read_status("pulse_abort");
  endtask

  task automatic test_rst_mid();
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)));
    KB_DATA = 1'b1;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    mq.delete(); m_ovr = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
    checks++;
    if ({DOUT, IRQ, BUSY} !== 10'd0) begin
      errors++; $display("FAIL rst_mid got %h/%b/%b want 0", DOUT, IRQ, BUSY);
    end
    read_status("rst_mid");
    send_frame(8'h29, 1'b0, 1'b0, 1'b1);
    read_data("rst_29");
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      int kind;
      kind = $urandom_range(0, 5);
      send_frame(8'($urandom), kind == 0, kind == 1, 1'b0);
      check_irq("rand_irq");
      for (int r = $urandom_range(0, 2); r > 0; r--) begin
        if ($urandom_range(0, 1) == 1) read_status("rand");
        else read_data("rand");
      end
    end
    while (mq.size() != 0) read_data("rand_drain");
    read_status("rand_final");
    check_irq("rand_final");
  endtask

  initial begin
    test_reset();
    test_valid();
    test_parity();
    test_overflow();
    test_timeout();
    test_glitch();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
